// File: rtl/congestion_scheduler.sv
// Generic single-clock FIFO; pop data is the head entry shown combinationally, count is registered.
// Latency: a push is visible at the head one cycle later; caller must not push when full or pop when empty.
module fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

// Queues classifier levels and releases one per all_red rising edge (escalate at once, de-escalate one step).
// Latency: level valid the cycle after a boundary; backpressure via in_ready when full; watchdog drives fail-safe.
module congestion_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int RECOVER_FRAMES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_level,
  input  logic                          all_red,
  input  logic                          force_fail_safe,
  output logic [1:0]                    congestion_level,
  output logic                          fail_safe_en,
  output logic                          level_update,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RCW = $clog2(RECOVER_FRAMES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);
  localparam logic [RCW-1:0] RC_MAX = RCW'(RECOVER_FRAMES);

  typedef enum logic {NORMAL, FAILSAFE} wd_state_t;

  wd_state_t        state, state_next;
  logic [RCW-1:0]   rc, rc_next, rc_inc;
  logic [WDW-1:0]   wd, wd_next;
  logic             timeout;
  logic             accept;
  logic             boundary;
  logic             all_red_q;
  logic             pop_vld;
  logic [1:0]       pop_dat;

  assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign accept   = in_valid & in_ready;
  assign boundary = all_red & ~all_red_q;
  // Uses pre-push occupancy, so a frame arriving into an empty FIFO is never popped the same cycle.
  assign pop_vld  = boundary & (fifo_count != '0);

  fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_level_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (accept),
    .push_dat (in_level),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      all_red_q        <= 1'b0;
      congestion_level <= 2'd0;
      level_update     <= 1'b0;
    end else begin
      all_red_q    <= all_red;
      level_update <= pop_vld;
      if (pop_vld) begin
        if (pop_dat > congestion_level)
          congestion_level <= pop_dat;
        else if (pop_dat < congestion_level)
          congestion_level <= congestion_level - 2'd1;
      end
    end
  end

  always_comb begin
    wd_next = wd;
    if (accept)
      wd_next = '0;
    else if (wd != WD_MAX)
      wd_next = wd + WDW'(1);
  end

  assign timeout = (wd_next == WD_MAX);

  always_ff @(posedge clk) begin
    if (rst) wd <= '0;
    else     wd <= wd_next;
  end

  assign rc_inc = rc + RCW'(1);

  always_comb begin
    state_next = state;
    rc_next    = rc;
    case (state)
      NORMAL: begin
        if (force_fail_safe || timeout) begin
          state_next = FAILSAFE;
          rc_next    = '0;
        end
      end
      FAILSAFE: begin
        if (force_fail_safe) begin
          rc_next = '0;
        end else if (accept) begin
          if (rc_inc == RC_MAX) begin
            state_next = NORMAL;
            rc_next    = '0;
          end else begin
            rc_next = rc_inc;
          end
        end else if (timeout) begin
          rc_next = '0;
        end
      end
      default: begin
        state_next = NORMAL;
        rc_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      rc    <= '0;
    end else begin
      state <= state_next;
      rc    <= rc_next;
    end
  end

  assign fail_safe_en = (state == FAILSAFE);
endmodule

// File: doc/congestion_scheduler.md
# congestion_scheduler

Sits between the ML congestion classifier and `traffic_controller`, sequencing when classifier results reach the signal FSM. Buffers per-frame congestion levels in a small FIFO and releases one level per phase boundary (rising edge of the controller's `all_red`). Filters releases so escalation is immediate and de-escalation is one step per boundary. A frame-arrival watchdog drives the controller's `fail_safe_en` when the classifier stalls, and releases it after sustained recovery.

## Interface
- `FIFO_DEPTH`, 4: level FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 20000: idle cycles without an accepted frame before fail-safe asserts; ≥2.
- `RECOVER_FRAMES`, 3: consecutive accepted frames that clear fail-safe; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: classifier frame result valid.
- `in_ready` out 1: block can accept a frame.
- `in_level` in 2: frame congestion level, 0–3.
- `all_red` in 1: from `traffic_controller`; marks phase boundaries.
- `force_fail_safe` in 1: manual override; fail-safe held while high.
- `congestion_level` out 2: to `traffic_controller`.
- `fail_safe_en` out 1: to `traffic_controller`.
- `level_update` out 1: one-cycle pulse when `congestion_level` is (re)loaded.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- **Accept.** A frame is accepted when `in_valid && in_ready`. `in_ready = (fifo_count != FIFO_DEPTH)` is combinational from registered count.
- **Boundary.** A boundary is `all_red && !all_red_q`, where `all_red_q` is `all_red` registered once. A level held high produces one boundary only.
- **Pop.** On a boundary with the FIFO non-empty, the oldest entry `p` is popped. Let `L` be the current `congestion_level`:
  - `p > L`: `L <= p`.
  - `p < L`: `L <= L-1`.
  - `p == L`: `L` is unchanged.
  - In all three cases `level_update` pulses.
- **Empty at boundary.** No pop, `L` holds, no pulse.
- **Push and pop together.** Simultaneous accept and pop: both happen, count unchanged. At `FIFO_DEPTH` the push is blocked by `in_ready=0` even if a pop occurs that cycle. Empty FIFO with accept and boundary in the same cycle: the new frame is not popped that cycle.
- **Watchdog counter `wd`.** Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared to 0 on an accept.
  - Otherwise incremented, saturating at `TIMEOUT_CYCLES`.
- **Watchdog state machine.** Two states, NORMAL and FAILSAFE:
  - NORMAL → FAILSAFE when `wd` becomes `TIMEOUT_CYCLES` (the `TIMEOUT_CYCLES`-th consecutive non-accept cycle), or when `force_fail_safe` is 1. The recovery count `rc` is cleared on entry.
  - In FAILSAFE, each accept increments `rc`. `wd` reaching `TIMEOUT_CYCLES` again clears `rc`.
  - FAILSAFE → NORMAL on the accept that makes `rc == RECOVER_FRAMES`, provided `force_fail_safe` is 0 that cycle.
  - `force_fail_safe` high holds FAILSAFE and clears `rc` every cycle.
- **Output in FAILSAFE.** `fail_safe_en = (state == FAILSAFE)`, registered. FIFO and level filtering keep operating in FAILSAFE.

## Timing
- **Reset values:**
  - Outputs: `congestion_level=0`, `fail_safe_en=0`, `level_update=0`, `fifo_count=0`, `in_ready=1`.
  - Internal: `all_red_q=0`, `wd=0`, `rc=0`, state NORMAL, FIFO pointers 0.
- **Reset mid-operation.** Discards all FIFO contents and returns to these values on the next edge.
- **Reset while `all_red` is high.** The first post-reset cycle sees `all_red_q=0` and therefore counts as a boundary (FIFO is empty, so no effect).
- **Boundary to level.** `all_red` high at posedge N with `all_red_q` low: `congestion_level` and `level_update` are valid after posedge N; `level_update` is low after posedge N+1.
- **Accept to pop.** A frame accepted at posedge N is poppable from posedge N+1.
- **Watchdog timing.**
  - Last accept at posedge N, none after: `fail_safe_en` rises after posedge `N+TIMEOUT_CYCLES`.
  - `force_fail_safe` high at posedge N: `fail_safe_en` is high after posedge N.
- **Recovery.** The `RECOVER_FRAMES`-th accept at posedge M drops `fail_safe_en` after posedge M.

## Test plan
All scenarios use `FIFO_DEPTH=4`, `TIMEOUT_CYCLES=100`, `RECOVER_FRAMES=3`.
- **Fill.** Push levels 1,2,3,0,2 back-to-back with no boundaries → first four accepted, `in_ready=0` at `fifo_count=4`, fifth held until a pop.
- **Filter.** FIFO holds 3,0,0,2, `L=0`; pulse `all_red` four times (3-cycle pulses) → `L` = 3,2,1,2, one `level_update` per pulse; a fifth pulse with the FIFO empty → `L` stays 2, no pulse.
- **Wide `all_red`.** Hold `all_red` high for 50 cycles with 2 entries queued → exactly one pop, `fifo_count` 2→1.
- **Timeout and recovery.** Accept at cycle 10, then idle → `fail_safe_en` rises after cycle 110. Then three accepts at 20-cycle spacing → `fail_safe_en` falls after the third.
- **Recovery broken.** In FAILSAFE, two accepts, then 100 idle cycles, then three accepts → stays high until the third of the final three.
- **Force and reset.**
  - Assert `force_fail_safe` for 10 cycles with frames every cycle → `fail_safe_en` high throughout; after release it clears on the third accept.
  - Assert `rst` one cycle with `fifo_count=3`, `L=2` → all outputs at reset values the next cycle.
